// File: rtl/aes_key_scheduler.sv
// ============================================================================
//  Module      : aes_key_scheduler
//  Description : AES-128 key expansion, one round key per cycle, with a
//                registered read port over the eleven stored round keys.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_scheduler #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         busy,
    output logic         keys_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_CNT = 4'(NR - 1);

    // FIPS-197 S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'h7ff - {x, 3'b000};
        return c_SBOX[idx -: 8];
    endfunction

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [127:0] r_rk [0:NR];
    logic [127:0] r_rd_key;
    logic         r_busy;
    logic         r_key_ready;
    logic         r_keys_valid;

    logic [127:0] w_cur;
    logic [127:0] w_next;
    logic [127:0] w_rd_sel;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [7:0]   w_rcon;
    logic [31:0]  w_o0, w_o1, w_o2, w_o3;

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < NR; i++) begin
            if (r_cnt == 4'(i)) begin
                w_cur = r_rk[i];
            end
        end
    end

    always_comb begin
        case (r_cnt)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // RotWord on w3: the most significant byte moves to the bottom.
    assign w_rot = {w_cur[23:0], w_cur[31:24]};

    generate
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            assign w_sub[8*b +: 8] = sbox(w_rot[8*b +: 8]);
        end
    endgenerate

    assign w_t    = w_sub ^ {w_rcon, 24'h0};
    assign w_o0   = w_cur[127:96] ^ w_t;
    assign w_o1   = w_cur[95:64]  ^ w_o0;
    assign w_o2   = w_cur[63:32]  ^ w_o1;
    assign w_o3   = w_cur[31:0]   ^ w_o2;
    assign w_next = {w_o0, w_o1, w_o2, w_o3};

    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rd_round == 4'(i)) begin
                w_rd_sel = r_rk[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_rd_key     <= '0;
            r_busy       <= 1'b0;
            r_key_ready  <= 1'b1;
            r_keys_valid <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                r_rk[i] <= '0;
            end
        end else begin
            // Non-blocking read sees the pre-write value on a same-entry write.
            r_rd_key <= w_rd_sel;
            case (r_state)
                IDLE, DONE: begin
                    if (key_valid) begin
                        r_rk[0]      <= key_in;
                        r_cnt        <= 4'd0;
                        r_keys_valid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_key_ready  <= 1'b0;
                        r_state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    for (int i = 1; i <= NR; i++) begin
                        if (r_cnt == 4'(i - 1)) begin
                            r_rk[i] <= w_next;
                        end
                    end
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_LAST_CNT) begin
                        r_keys_valid <= 1'b1;
                        r_busy       <= 1'b0;
                        r_key_ready  <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_key_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rd_key     = r_rd_key;
    assign busy       = r_busy;
    assign key_ready  = r_key_ready;
    assign keys_valid = r_keys_valid;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_scheduler.sv
// ============================================================================
//  Module      : tb_aes_key_scheduler
//  Description : Self-checking bench for aes_key_scheduler against a FIPS-197
//                word-recurrence model with an arithmetically derived S-box.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_key_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         busy;
    logic         keys_valid;

    int tests = 0;
    int fails = 0;

    logic [127:0] exp_rk [0:10];
    logic [127:0] cur_rk [0:10];

    localparam logic [127:0] c_FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_key_scheduler #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .rd_round   (rd_round),
        .rd_key     (rd_key),
        .busy       (busy),
        .keys_valid (keys_valid)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    task automatic model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic read_check(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        @(negedge clk);
        rd_round = idx;
        @(negedge clk);
        check(tag, rd_key, exp);
    endtask

    task automatic sweep();
        for (int i = 0; i < 16; i++) begin
            read_check(4'(i), (i <= 10) ? cur_rk[i] : 128'h0, $sformatf("sweep_rk%0d", i));
        end
    endtask

    task automatic run_key(input logic [127:0] key, input bit junk);
        logic [127:0] old1;
        int n;
        model(key);
        old1 = cur_rk[1];
        @(negedge clk);
        key_in    = key;
        key_valid = 1'b1;
        rd_round  = 4'd1;
        @(negedge clk);
        check("busy_after_accept", 128'(busy), 128'(1));
        check("ready_in_expand", 128'(key_ready), 128'(0));
        check("kv_clear_on_accept", 128'(keys_valid), 128'(0));
        if (junk) key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        else key_valid = 1'b0;
        n = 0;
        while (!keys_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 9) key_valid = 1'b0;
            check("rk1_read_during_expand", rd_key, (n == 1) ? old1 : exp_rk[1]);
            check("busy_during_expand", 128'(busy), 128'(n < 10));
            check("ready_during_expand", 128'(key_ready), 128'(n >= 10));
        end
        check("latency_to_keys_valid", 128'(n), 128'(10));
        for (int i = 0; i <= 10; i++) cur_rk[i] = exp_rk[i];
        sweep();
        check("keys_valid_in_done", 128'(keys_valid), 128'(1));
        check("busy_in_done", 128'(busy), 128'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rd_round  = 4'd0;
        for (int i = 0; i <= 10; i++) cur_rk[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_rd_key", rd_key, 128'h0);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_keys_valid", 128'(keys_valid), 128'(0));
        check("reset_key_ready", 128'(key_ready), 128'(1));
        rst_n = 1'b1;

        run_key(c_FIPS_KEY, 1'b0);
        read_check(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
        read_check(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");

        run_key(128'h0, 1'b0);
        read_check(4'd1,  128'h62636363626363636263636362636363, "zero_rk1");
        read_check(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");

        run_key({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);

        // Abort an expansion partway through with an asynchronous reset.
        @(negedge clk);
        key_in    = c_FIPS_KEY;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_keys_valid", 128'(keys_valid), 128'(0));
        check("abort_key_ready", 128'(key_ready), 128'(1));
        check("abort_rd_key", rd_key, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 10; i++) cur_rk[i] = '0;
        sweep();

        run_key(c_FIPS_KEY, 1'b0);
        read_check(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "rerun_fips_rk1");
        read_check(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "rerun_fips_rk10");

        for (int k = 0; k < 3; k++) begin
            run_key({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_key_scheduler.md
AES_KEY_SCHEDULER -- requirements
Module: aes_key_scheduler

Interface
REQ-001 Parameter NR, default 10: number of AES-128 expansion rounds; fixed at 10, other values unsupported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 key_in  input  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0].
REQ-005 key_valid  input  1  key_in is valid this cycle.
REQ-006 key_ready  output  1  block can accept a key; transfer occurs on an edge where key_valid and key_ready are both 1.
REQ-007 rd_round  input  4  index of the round key to read, 0..10.
REQ-008 rd_key  output  128  registered round key selected by rd_round.
REQ-009 busy  output  1  expansion in progress.
REQ-010 keys_valid  output  1  all 11 round keys rk[0..10] are stored and consistent with the last accepted key.

Function
REQ-011 The FSM SHALL have three states: IDLE, EXPAND and DONE.
REQ-012 In IDLE and DONE, key_ready SHALL be 1; in EXPAND, key_ready SHALL be 0 and key_valid SHALL be ignored.
REQ-013 On acceptance (edge E0), the block SHALL:
- write rk[0] = key_in;
- clear round counter cnt to 0;
- clear keys_valid;
- enter EXPAND.
REQ-014 On each EXPAND edge, the block SHALL:
- write rk[cnt+1] = next(rk[cnt], rcon[cnt]);
- increment cnt;
- throughput: one round key per cycle.
REQ-015 next() SHALL compute:
- t = SubWord(RotWord(w3)) XOR {rcon,24'h0};
- RotWord = one-byte left rotation;
- SubWord = the FIPS-197 S-box applied to each byte;
- outputs o0 = w0^t, o1 = w1^o0, o2 = w2^o1, o3 = w3^o2.
REQ-016 The rcon byte for cnt = 0..9 SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-017 The edge that writes rk[10] (E10) SHALL move the FSM to DONE and set keys_valid = 1, so keys_valid is first high in the cycle after E10.
- Latency: 10 cycles from acceptance to keys_valid.
REQ-018 busy SHALL be 1 exactly while the state is EXPAND.
REQ-019 Acceptance in DONE SHALL restart expansion per REQ-013; keys_valid falls at that edge.
REQ-020 rd_key SHALL update on every edge:
- rd_key <= rk[rd_round] for rd_round 0..10;
- rd_key <= 128'h0 for rd_round 11..15;
- read latency: 1 cycle.
REQ-021 A read during EXPAND SHALL return the register contents at that edge: an already-written new key, or the value left from the previous expansion (zero after reset). It SHALL NOT return X.
REQ-022 A read and a write of the same rk entry on the same edge SHALL return the pre-write value.
REQ-023 cnt SHALL be 4 bits and SHALL never exceed 10; cnt is a don't-care outside EXPAND.

Reset
REQ-024 While rst_n = 0, the block SHALL hold:
- state = IDLE;
- cnt = 0;
- rk[0..10] = 0;
- rd_key = 0;
- busy = 0, keys_valid = 0, key_ready = 1.
REQ-025 Reset asserted mid-EXPAND SHALL abort immediately. After release, the block SHALL accept a new key and produce correct keys with no residue from the aborted run.

Verification
REQ-026 Key 2b7e151628aed2a6abf7158809cf4f3c -> rk[1] = a0fafe1788542cb123a339392a6c7605, rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6, keys_valid high 10 cycles after acceptance.
REQ-027 All-zero key -> rk[1] = 62636363626363636263636362636363, rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-028 key_valid held high with a different key_in during EXPAND -> key_ready = 0, key_in ignored, results equal the first key's expansion.
REQ-029 rst_n pulsed low at cycle 5 of EXPAND -> all outputs go to reset values immediately; re-run with the FIPS key passes REQ-026.
REQ-030 rd_round swept 0..15 in DONE -> rd_key equals rk[i] one cycle later for 0..10, and 0 for 11..15.
REQ-031 Second key accepted in DONE -> keys_valid drops at that edge, busy = 1 for 10 cycles, new keys correct.
